// File: rtl/base_arb_pkg.sv
// Shared arbiter helpers: one-hot to binary encoding and the index-width rule.
package base_arb_pkg;

  localparam int ENCW_MIN = 1;
  localparam int OH_MAXW  = 64;

  // Width of a binary way index; never narrower than one bit.
  function automatic int encw_of(input int ways);
    int w;
    w = $clog2(ways);
    return (w < ENCW_MIN) ? ENCW_MIN : w;
  endfunction

  // Binary index of the set bit in a one-hot vector (bit i is way i); 0 if none set.
  function automatic int unsigned onehot2enc(input logic [OH_MAXW-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < OH_MAXW; i++) begin
      if (oh[i]) r = r | 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/base_prienc_lp.sv
// Fixed-priority selector: highest-index set bit of req wins, output is one-hot.
module base_prienc_lp #(
  parameter int ways = 2
) (
  input  logic [0:ways-1] req,
  output logic [0:ways-1] gnt
);

  always_comb begin
    gnt = '0;
    for (int w = 0; w < ways; w++) begin
      if (req[w]) begin
        gnt    = '0;
        gnt[w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/base_req_arb.sv
// Fixed-priority request arbiter with per-way outstanding counters and a
// registered one-hot grant port.
module base_req_arb
  import base_arb_pkg::*;
#(
  parameter int ways = 2,
  parameter int cntw = 2,
  parameter int encw = encw_of(ways)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [0:ways-1] i_req,
  output logic            o_v,
  input  logic            i_r,
  output logic [0:ways-1] o_way,
  output logic [0:encw-1] o_enc,
  output logic            o_pend,
  output logic            o_err
);

  localparam logic [cntw-1:0] CNT_MAX = {cntw{1'b1}};

  logic [0:ways-1]    cand;
  logic [0:ways-1]    sel;
  logic [0:ways-1]    ovf;
  logic [OH_MAXW-1:0] sel_le;
  logic [0:encw-1]    sel_enc;
  logic               ld;

  // Handshake: a grant transfers in a cycle with o_v=1 and i_r=1; while
  // o_v=1 and i_r=0 the output register holds. An empty register always loads.
  assign ld     = ~o_v | i_r;
  assign o_pend = |cand;

  base_prienc_lp #(.ways(ways)) u_prienc (
    .req (cand),
    .gnt (sel)
  );

  always_comb begin
    sel_le = '0;
    for (int w = 0; w < ways; w++) sel_le[w] = sel[w];
    sel_enc = encw'(onehot2enc(sel_le));
  end

  for (genvar w = 0; w < ways; w++) begin : g_cnt
    logic [cntw-1:0] cnt_q;
    logic            dec;
    logic            inc;

    // sel is one-hot over nonzero counters, so a selected way never underflows.
    assign dec     = ld & sel[w];
    assign inc     = i_req[w];
    assign cand[w] = (cnt_q != '0);
    assign ovf[w]  = inc & ~dec & (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_v   <= 1'b0;
      o_way <= '0;
      o_enc <= '0;
      o_err <= 1'b0;
    end else begin
      if (|ovf) o_err <= 1'b1;
      if (ld) begin
        // With no candidates sel and sel_enc are zero, clearing the port.
        o_v   <= |cand;
        o_way <= sel;
        o_enc <= sel_enc;
      end
    end
  end

endmodule

// File: tb/tb_base_req_arb.sv
// Directed bench for base_req_arb (ways=4, cntw=2).
module tb_base_req_arb;

  logic       clk;
  logic       reset_n;
  logic [0:3] i_req;
  logic       i_r;
  logic       o_v;
  logic [0:3] o_way;
  logic [0:1] o_enc;
  logic       o_pend;
  logic       o_err;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_g;
  logic [6:0] got_g;

  base_req_arb #(.ways(4), .cntw(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .o_v     (o_v),
    .i_r     (i_r),
    .o_way   (o_way),
    .o_enc   (o_enc),
    .o_pend  (o_pend),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
    got_g = {o_v, o_way, o_enc};
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_req = 4'b1111; i_r = 1'b0;
    step(); step(); step();
    checks++;
    if ({got_g, o_err, o_pend} !== 9'b0) begin
      errors++; $display("FAIL reset_outs: got %b exp %b", {got_g, o_err, o_pend}, 9'b0);
    end
    reset_n = 1'b1; i_req = 4'b0000;
    step();
    i_req = 4'b1000;                          // way 0 pulse, cycle N
    step(); i_req = 4'b0000;
    checks++;
    if ({o_pend, o_v} !== 2'b10) begin
      errors++; $display("FAIL lat_pend_n1: got %b exp %b", {o_pend, o_v}, 2'b10);
    end
    step();
    exp_g = {1'b1, 4'b1000, 2'd0};
    checks++;
    if (got_g !== exp_g || o_pend !== 1'b0) begin
      errors++; $display("FAIL lat_grant_n2: got %b/%b exp %b/0", got_g, o_pend, exp_g);
    end
    i_r = 1'b1;
    step();
    checks++;
    if (got_g !== 7'b0) begin
      errors++; $display("FAIL lat_drain: got %b exp %b", got_g, 7'b0);
    end
  endtask

  task automatic test_priority();
    logic [6:0] exp_seq [4];
    exp_seq[0] = {1'b1, 4'b0001, 2'd3};
    exp_seq[1] = {1'b1, 4'b0010, 2'd2};
    exp_seq[2] = {1'b1, 4'b1000, 2'd0};
    exp_seq[3] = 7'b0;
    i_r = 1'b1; i_req = 4'b1011;
    step(); i_req = 4'b0000;
    checks++;
    if ({o_pend, o_v} !== 2'b10) begin
      errors++; $display("FAIL prio_pend: got %b exp %b", {o_pend, o_v}, 2'b10);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (got_g !== exp_seq[k]) begin
        errors++; $display("FAIL prio_grant%0d: got %b exp %b", k, got_g, exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    i_r = 1'b0; i_req = 4'b0100;
    step(); i_req = 4'b0000;
    step();
    exp_g = {1'b1, 4'b0100, 2'd1};
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_g !== exp_g) begin
        errors++; $display("FAIL bp_hold%0d: got %b exp %b", k, got_g, exp_g);
      end
      i_req = (k == 0) ? 4'b0001 : 4'b0000;
      step();
    end
    i_req = 4'b0000; i_r = 1'b1;
    step();
    exp_g = {1'b1, 4'b0001, 2'd3};
    checks++;
    if (got_g !== exp_g) begin
      errors++; $display("FAIL bp_next: got %b exp %b", got_g, exp_g);
    end
    step();
    checks++;
    if (got_g !== 7'b0 || o_pend !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got %b/%b exp %b/0", got_g, o_pend, 7'b0);
    end
  endtask

  task automatic test_inc_dec();
    i_r = 1'b1; i_req = 4'b0010;
    step();                                   // cnt[2]=1, load happens next edge
    i_req = 4'b0010;
    step(); i_req = 4'b0000;
    exp_g = {1'b1, 4'b0010, 2'd2};
    checks++;
    if (got_g !== exp_g || o_pend !== 1'b1) begin
      errors++; $display("FAIL incdec_first: got %b/%b exp %b/1", got_g, o_pend, exp_g);
    end
    step();
    checks++;
    if (got_g !== exp_g || o_pend !== 1'b0) begin
      errors++; $display("FAIL incdec_second: got %b/%b exp %b/0", got_g, o_pend, exp_g);
    end
    step();
    checks++;
    if (got_g !== 7'b0) begin
      errors++; $display("FAIL incdec_idle: got %b exp %b", got_g, 7'b0);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] exp_seq [4];
    exp_seq[0] = {1'b1, 4'b0100, 2'd1};
    exp_seq[1] = {1'b1, 4'b0100, 2'd1};
    exp_seq[2] = {1'b1, 4'b0100, 2'd1};
    exp_seq[3] = 7'b0;
    i_r = 1'b0; i_req = 4'b0001;              // park a way-3 grant
    step(); i_req = 4'b0000;
    step();
    for (int k = 0; k < 4; k++) begin
      i_req = 4'b0100;
      step();
      if (k == 2) begin
        checks++;
        if (o_err !== 1'b0) begin
          errors++; $display("FAIL ovf_early: got %b exp 0", o_err);
        end
      end
    end
    i_req = 4'b0000;
    checks++;
    if (o_err !== 1'b1 || got_g !== {1'b1, 4'b0001, 2'd3}) begin
      errors++; $display("FAIL ovf_set: got err=%b g=%b exp err=1 g=%b", o_err, got_g, {1'b1, 4'b0001, 2'd3});
    end
    i_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (got_g !== exp_seq[k]) begin
        errors++; $display("FAIL ovf_drain%0d: got %b exp %b", k, got_g, exp_seq[k]);
      end
    end
    checks++;
    if (o_err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b exp 1", o_err);
    end
  endtask

  task automatic test_async_reset();
    i_r = 1'b0; i_req = 4'b1111;
    step(); i_req = 4'b0000;
    step();
    checks++;
    if ({o_v, o_pend, o_err} !== 3'b111) begin
      errors++; $display("FAIL arst_pre: got %b exp %b", {o_v, o_pend, o_err}, 3'b111);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({o_v, o_way, o_enc, o_pend, o_err} !== 9'b0) begin
      errors++; $display("FAIL arst_clear: got %b exp %b", {o_v, o_way, o_enc, o_pend, o_err}, 9'b0);
    end
    step(); reset_n = 1'b1;
    i_r = 1'b1;
    step(); step();
    checks++;
    if ({got_g, o_pend} !== 8'b0) begin
      errors++; $display("FAIL arst_after: got %b exp %b", {got_g, o_pend}, 8'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_req = '0; i_r = 1'b0;
    test_reset();
    test_priority();
    test_backpressure();
    test_inc_dec();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
